// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Round-robin arbiter and select sequencer for a 4-to-1 x DW-bit lane mux.
//   One requester owns the output lane at a time. Under contention an owner
//   is preempted after HOLD_CYCLES consecutive grant cycles. A manual mode
//   hands the select over to board switches. The mux select, the grant and
//   the selected lane data are all registered and aligned to the same cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   req         level request per requester
//   data_in     packed lanes, lane i = data_in[DW*i +: DW]
//   manual_en   manual override enable
//   manual_sel  manual select value
//   sel         registered mux select
//   grant       registered one-hot grant, zero when nobody owns the lane
//   dout        registered selected lane
//   dout_valid  dout carries data from a granted or manual lane
//   busy        arbiter is in GRANT
module mux_sel_arbiter #(
   parameter int NREQ        = 4,
   parameter int DW          = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data_in,
   input  logic               manual_en,
   input  logic [1:0]         manual_sel,
   output logic [1:0]         sel,
   output logic [NREQ-1:0]    grant,
   output logic [DW-1:0]      dout,
   output logic               dout_valid,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, GRANT, MANUAL} state_t;

   localparam bit         HOLD_OK  = (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 15) && (NREQ == 4);
   localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYCLES - 1);

   state_t     state, state_n;
   logic [1:0] owner, owner_n;
   logic [1:0] ptr, ptr_n;
   logic [3:0] hold_cnt, hold_n;
   logic [1:0] sel_n;
   logic [NREQ-1:0] grant_n;
   logic [NREQ-1:0] others;
   logic [DW-1:0]   dout_n;
   logic            active_n;

   // Packed view of the lanes: lane[i] is data_in[DW*i +: DW].
   logic [NREQ-1:0][DW-1:0] lane;
   assign lane = data_in;

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
      return {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // First requester at or after p, wrapping modulo 4.
   function automatic logic [1:0] pick(input logic [NREQ-1:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign others = req & ~onehot(owner);

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      case (state)
         IDLE: begin
            if (manual_en) begin
               state_n = MANUAL;
            end else if (|req) begin
               state_n = GRANT;
               owner_n = pick(req, ptr);
               hold_n  = 4'd0;
            end
         end
         GRANT: begin
            if (manual_en) begin
               state_n = MANUAL;
            end else if (!req[owner]) begin
               // Release: rotation resumes just past the old owner, and a
               // waiting requester takes over on this same edge.
               ptr_n = owner + 2'd1;
               if (|req) begin
                  owner_n = pick(req, owner + 2'd1);
                  hold_n  = 4'd0;
               end else begin
                  state_n = IDLE;
               end
            end else if (|others) begin
               if (hold_cnt == HOLD_MAX) begin
                  ptr_n   = owner + 2'd1;
                  owner_n = pick(others, owner + 2'd1);
                  hold_n  = 4'd0;
               end else begin
                  hold_n = hold_cnt + 4'd1;
               end
            end else if (hold_cnt != HOLD_MAX) begin
               // Sole requester keeps the lane; count saturates.
               hold_n = hold_cnt + 4'd1;
            end
         end
         MANUAL: begin
            if (!manual_en) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         GRANT:   sel_n = owner_n;
         MANUAL:  sel_n = manual_sel;
         default: sel_n = sel;
      endcase

      grant_n  = (state_n == GRANT) ? onehot(owner_n) : '0;
      active_n = (state_n != IDLE);
      dout_n   = active_n ? lane[sel_n] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 2'd0;
         ptr        <= 2'd0;
         hold_cnt   <= 4'd0;
         sel        <= 2'd0;
         grant      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         ptr        <= ptr_n;
         hold_cnt   <= hold_n;
         sel        <= sel_n;
         grant      <= grant_n;
         dout       <= dout_n;
         dout_valid <= active_n;
      end
   end

   assign busy = (state == GRANT);

   hold_range_a: assert property (@(posedge clk) disable iff (rst) HOLD_OK)
      else $error("mux_sel_arbiter: HOLD_CYCLES must be 1..15 and NREQ must be 4");

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter. Two instances run side by side
// (HOLD_CYCLES=4 and HOLD_CYCLES=1) on the same stimulus. The driver
// computes expected outputs from a behavioural model and queues them; a
// monitor pops and compares after every rising edge.
module tb_mux_sel_arbiter;

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] sel;
      logic [1:0] dout;
      logic       dv;
      logic       busy;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] data_in;
   logic       manual_en;
   logic [1:0] manual_sel;

   logic [1:0] sel0, sel1;
   logic [3:0] grant0, grant1;
   logic [1:0] dout0, dout1;
   logic       dv0, dv1, busy0, busy1;

   int n_chk  = 0;
   int n_fail = 0;

   obs_t exp_q0[$];
   obs_t exp_q1[$];

   // Model state per instance: mode 0=idle 1=granted 2=manual.
   int m_mode[2], m_owner[2], m_ptr[2], m_hold[2], m_sel[2];
   int hold_lim[2] = '{4, 1};

   always #5 clk = ~clk;

   mux_sel_arbiter #(.NREQ(4), .DW(2), .HOLD_CYCLES(4)) dut0 (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in),
      .manual_en(manual_en), .manual_sel(manual_sel),
      .sel(sel0), .grant(grant0), .dout(dout0), .dout_valid(dv0), .busy(busy0));

   mux_sel_arbiter #(.NREQ(4), .DW(2), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in),
      .manual_en(manual_en), .manual_sel(manual_sel),
      .sel(sel1), .grant(grant1), .dout(dout1), .dout_valid(dv1), .busy(busy1));

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return p;
   endfunction

   task automatic model_reset(input int k);
      m_mode[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_sel[k] = 0;
   endtask

   task automatic model_step(input int k, input bit r, input logic [3:0] rq,
                             input bit me, input logic [1:0] ms,
                             input logic [7:0] d, output obs_t e);
      logic [3:0] oth;
      logic [7:0] dd;
      int         lim;
      lim = hold_lim[k];
      dd  = d;
      if (r) begin
         model_reset(k);
         e = '0;
         return;
      end
      case (m_mode[k])
         0: begin
            if (me) m_mode[k] = 2;
            else if (rq != 0) begin
               m_mode[k] = 1; m_owner[k] = pick(rq, m_ptr[k]); m_hold[k] = 0;
            end
         end
         1: begin
            oth = rq & ~(4'b0001 << m_owner[k]);
            if (me) m_mode[k] = 2;
            else if (!rq[m_owner[k]]) begin
               m_ptr[k] = (m_owner[k] + 1) % 4;
               if (rq != 0) begin
                  m_owner[k] = pick(rq, m_ptr[k]); m_hold[k] = 0;
               end else m_mode[k] = 0;
            end else if (oth != 0 && m_hold[k] == lim - 1) begin
               m_ptr[k] = (m_owner[k] + 1) % 4;
               m_owner[k] = pick(oth, m_ptr[k]);
               m_hold[k] = 0;
            end else if (m_hold[k] < lim - 1) m_hold[k]++;
         end
         default: if (!me) m_mode[k] = 0;
      endcase
      if (m_mode[k] == 1) m_sel[k] = m_owner[k];
      else if (m_mode[k] == 2) m_sel[k] = int'(ms);
      e.grant = (m_mode[k] == 1) ? (4'b0001 << m_owner[k]) : 4'b0000;
      e.sel   = 2'(m_sel[k]);
      e.dv    = (m_mode[k] != 0);
      e.dout  = e.dv ? dd[2*m_sel[k] +: 2] : 2'b00;
      e.busy  = (m_mode[k] == 1);
   endtask

   task automatic cmp(input string nm, input obs_t got, input obs_t exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant=%b sel=%0d dout=%b valid=%b busy=%b, expected grant=%b sel=%0d dout=%b valid=%b busy=%b",
                  nm, got.grant, got.sel, got.dout, got.dv, got.busy,
                  exp.grant, exp.sel, exp.dout, exp.dv, exp.busy);
      end
   endtask

   task automatic chk_val(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Drive one cycle: inputs set in the low phase, expectation queued for the
   // coming rising edge, return at the next falling edge.
   task automatic step(input bit r, input logic [3:0] rq, input bit me,
                       input logic [1:0] ms, input logic [7:0] d);
      obs_t e0, e1;
      rst = r; req = rq; manual_en = me; manual_sel = ms; data_in = d;
      model_step(0, r, rq, me, ms, d, e0);
      model_step(1, r, rq, me, ms, d, e1);
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
      @(negedge clk);
   endtask

   // Monitor: compare registered outputs shortly after every rising edge.
   always @(posedge clk) begin
      #2;
      if (exp_q0.size() > 0) cmp("hold4", {grant0, sel0, dout0, dv0, busy0}, exp_q0.pop_front());
      if (exp_q1.size() > 0) cmp("hold1", {grant1, sel1, dout1, dv1, busy1}, exp_q1.pop_front());
   end

   localparam logic [7:0] D = 8'b11_10_01_00;
   int cseq[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 8, 8, 8, 8, 1};

   initial begin
      logic [3:0] rq;
      bit         me;
      model_reset(0);
      model_reset(1);
      rst = 1'b1; req = 4'hF; manual_en = 1'b0; manual_sel = 2'd0; data_in = D;

      // Reset with all requesting, then release.
      repeat (3) step(1, 4'hF, 0, 0, D);
      chk_val("reset grant", int'(grant0), 0);
      chk_val("reset dout_valid", int'(dv0), 0);
      step(0, 4'hF, 0, 0, D);
      chk_val("first grant after reset", int'(grant0), 1);
      chk_val("first sel after reset", int'(sel0), 0);
      step(0, 4'h0, 0, 0, D);

      // Single requester, then release to idle (sel holds).
      step(0, 4'b0100, 0, 0, D);
      chk_val("single grant", int'(grant0), 4);
      chk_val("single dout", int'(dout0), 2);
      step(0, 4'b0000, 0, 0, D);
      chk_val("idle grant", int'(grant0), 0);
      chk_val("idle sel holds", int'(sel0), 2);

      // Contention with ptr back at 0.
      step(1, 4'b0000, 0, 0, D);
      for (int i = 0; i < 13; i++) begin
         step(0, 4'b1011, 0, 0, D);
         chk_val("contention hold4 grant", int'(grant0), cseq[i]);
      end

      // Zero-gap handoff from owner 1 to owner 3.
      step(1, 4'b0000, 0, 0, D);
      step(0, 4'b0010, 0, 0, D);
      step(0, 4'b1010, 0, 0, D);
      step(0, 4'b1000, 0, 0, D);
      chk_val("handoff grant", int'(grant0), 8);

      // Manual override mid-grant, then back to normal.
      step(1, 4'b0000, 0, 0, D);
      step(0, 4'b0100, 0, 0, D);
      step(0, 4'b0100, 1, 2'd3, D);
      chk_val("manual grant", int'(grant0), 0);
      chk_val("manual sel", int'(sel0), 3);
      chk_val("manual dout", int'(dout0), 3);
      step(0, 4'b0100, 0, 2'd3, D);
      chk_val("manual exit idle", int'(grant0), 0);
      step(0, 4'b0100, 0, 2'd3, D);
      chk_val("manual exit regrant", int'(grant0), 4);

      // Asynchronous reset pulse between edges while owner 3 is granted.
      step(1, 4'b0000, 0, 0, D);
      step(0, 4'b1000, 0, 0, D);
      rst = 1'b1;
      #1;
      chk_val("async rst grant", int'(grant0), 0);
      chk_val("async rst dout_valid", int'(dv0), 0);
      chk_val("async rst sel", int'(sel1), 0);
      rst = 1'b0;
      model_reset(0);
      model_reset(1);
      step(0, 4'b1010, 0, 0, D);
      chk_val("post-reset lowest index", int'(grant0), 2);

      // Randomised traffic.
      rq = 4'b0000;
      me = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 29) == 0) me = ~me;
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         step($urandom_range(0, 299) == 0, rq, me, 2'($urandom), 8'($urandom));
      end
      step(0, 4'b0000, 0, 0, D);
      @(negedge clk);
      chk_val("scoreboard drained", exp_q0.size() + exp_q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter and select sequencer for the board's 4-to-1 x 2-bit channel mux.
- Four requesters share one 2-bit output lane. The block grants one requester at a time and drives the mux select.
- It also produces a registered copy of the selected 2-bit lane.
- A manual mode hands select control to board switches; this replaces the direct switch-driven select used today.

Parameters:
NREQ, 4, number of requesters (fixed at 4; select width 2)
DW, 2, width of each data lane
HOLD_CYCLES, 4, maximum consecutive grant cycles under contention (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req  input  4  level request per requester
data_in  input  NREQ*DW  packed lanes; lane i = data_in[DW*i +: DW]
manual_en  input  1  manual override enable (switch)
manual_sel  input  2  manual select value (switches)
sel  output  2  registered mux select
grant  output  4  registered one-hot grant; all zero when nobody owns the lane
dout  output  DW  registered selected lane
dout_valid  output  1  dout carries data from a granted or manual lane
busy  output  1  state is GRANT

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, sel=0, grant=0, dout=0, dout_valid=0, busy=0.
  - Rotation pointer ptr=0, hold_cnt=0.
- States:
  - IDLE: no owner. sel holds its last value. grant=0.
  - GRANT: owner o; grant=onehot(o), sel=o.
  - MANUAL: grant=0; sel tracks manual_sel, registered (one-cycle lag).
- Pick function: first index i in ptr, ptr+1, ... ptr+3 (mod 4) with candidate req[i]=1.
- IDLE transitions:
  - manual_en=1 -> MANUAL. This has priority over req.
  - Else |req -> GRANT with owner=pick(req), hold_cnt=0.
  - Latency: req sampled at edge t gives grant visible after edge t (one clock).
- GRANT transitions, evaluated in priority order:
  - manual_en=1 -> MANUAL. grant drops at that edge; ptr unchanged.
  - req[o]=0 (release): ptr=o+1.
    - If other requests exist, hand off in the same edge to pick(req) from o+1, hold_cnt=0. This is a zero-gap handoff.
    - Otherwise go to IDLE.
  - req[o]=1 and hold_cnt=HOLD_CYCLES-1 and another request exists: preempt. Owner=pick(req & ~onehot(o)) from o+1, ptr=o+1, hold_cnt=0.
  - req[o]=1 and no other request: keep owner; hold_cnt saturates at HOLD_CYCLES-1.
  - Otherwise keep owner, hold_cnt+1.
- MANUAL transitions: manual_en=0 -> IDLE (no grant that edge); ptr and sel retained.
- Datapath:
  - Every edge, dout <= (state_next in GRANT or MANUAL) ? lane[sel_next] : 0.
  - dout_valid is set by the same condition.
  - dout is therefore aligned with sel/grant: same cycle, registered.
- HOLD_CYCLES=1: under sustained contention the owner rotates every cycle.
- Requester dropping and re-raising req: treated as release; it re-enters rotation at its normal round-robin position.
- Simultaneous release and manual_en=1: manual wins; ptr unchanged.
- req changes during MANUAL: ignored.
- Reset mid-grant: all outputs return to reset values immediately; arbitration restarts at index 0.
- Out-of-range HOLD_CYCLES: simulation assertion error.

Test Plan:
- Reset: rst=1 with req=4'hF -> grant=0, sel=0, dout=0, dout_valid=0. Deassert rst -> one edge later grant=0001, sel=0.
- Single requester: req=0100, data_in=8'b11_10_01_00 -> next edge grant=0100, sel=2, dout=2'b10, dout_valid=1. req=0 -> next edge IDLE, grant=0, dout_valid=0, sel stays 2.
- Contention, HOLD_CYCLES=4: req=1011 held -> owner 0 for 4 cycles, owner 1 for 4, owner 3 for 4, then owner 0. grant sequence 0001x4, 0010x4, 1000x4.
- Zero-gap handoff: owner 1, req 1010 -> 1000 -> next edge grant=1000, with no grant=0 cycle in between.
- Manual override mid-grant: owner 2, manual_en=1, manual_sel=3 -> next edge grant=0, sel=3, dout=lane3, dout_valid=1. manual_en=0 with req=0100 -> IDLE one cycle, then grant=0100 (ptr unchanged).
- Async reset mid-grant: owner 3, pulse rst between edges -> outputs return to reset values before the next edge. After release, first grant goes to the lowest active index.
